// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the systolic-array output path.
package mem_pkg;

  localparam int BITS_C_DEF = 16;
  localparam int DIM_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } deskew_state_e;

endpackage

// File: rtl/shift_delay.sv
// Enable-gated delay line of DEPTH registers; q is the oldest stage.
module shift_delay #(
  parameter int DEPTH = 1,
  parameter int BITS  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [BITS-1:0] d,
  output logic [BITS-1:0] q
);

  logic [BITS-1:0] stage_q [DEPTH];
  logic [BITS-1:0] stage_d [DEPTH];

  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      stage_d[s] = stage_q[s];
    end
    if (en) begin
      stage_d[0] = d;
      for (int s = 1; s < DEPTH; s++) begin
        stage_d[s] = stage_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < DEPTH; s++) begin
      if (rst) stage_q[s] <= '0;
      else     stage_q[s] <= stage_d[s];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/memc_deskew.sv
// Re-aligns the diagonally skewed result lanes of a DIM x DIM systolic array
// into whole rows, with row tagging and tile-level busy/done framing.
module memc_deskew
  import mem_pkg::*;
#(
  parameter int BITS_C = BITS_C_DEF,
  parameter int DIM    = DIM_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      start,
  input  logic [DIM*BITS_C-1:0]     Cin,
  output logic [DIM*BITS_C-1:0]     Cout,
  output logic                      out_valid,
  output logic [$clog2(DIM)-1:0]    row_idx,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                dbg_state
);

  localparam int CW = $clog2(2*DIM);
  localparam int RW = $clog2(DIM);

  // Lane i enters i steps late, so DIM-i stages line every lane up on one row.
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    shift_delay #(
      .DEPTH (DIM - i),
      .BITS  (BITS_C)
    ) u_dly (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (Cin[i*BITS_C +: BITS_C]),
      .q   (Cout[i*BITS_C +: BITS_C])
    );
  end

  deskew_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_idx_q, row_idx_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // out_valid is a single-cycle strobe: Cout carries row row_idx exactly in
  // the cycles where it is high; there is no back-pressure.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_idx_d   = row_idx_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    if (done_q) busy_d = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (start && !busy_q) begin
            state_d = FILL;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
        end
        FILL: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DIM-2)) begin
            state_d     = DRAIN;
            out_valid_d = 1'b1;
            row_idx_d   = '0;
          end
        end
        DRAIN: begin
          cnt_d       = cnt_q + CW'(1);
          out_valid_d = 1'b1;
          row_idx_d   = RW'(cnt_q - CW'(DIM-2));
          if (cnt_q == CW'(2*DIM-3)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      row_idx_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_idx_q   <= row_idx_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign row_idx   = row_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_memc_deskew.sv
// Bench for memc_deskew at DIM=4, BITS_C=16: skewed tiles in, rows checked
// against an expected-row queue filled when each tile is started.
module tb_memc_deskew;
  import mem_pkg::*;

  localparam int DIM  = 4;
  localparam int BITS = 16;
  localparam int W    = 2 + 1 + DIM*BITS;

  logic                clk = 1'b0;
  logic                rst, en, start;
  logic [DIM*BITS-1:0] cin, cout;
  logic                out_valid, busy, done;
  logic [1:0]          row_idx, dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int tile_step = -1;
  int mode = 0;
  logic [15:0] signed_tab [4] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000};

  memc_deskew #(.BITS_C(BITS), .DIM(DIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .Cin       (cin),
    .Cout      (cout),
    .out_valid (out_valid),
    .row_idx   (row_idx),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lane_val(input int lane, input int row);
    if (mode == 0) return 16'(10*row + lane);
    return signed_tab[(lane + row) % 4];
  endfunction

  function automatic logic [W-1:0] exp_row(input int r);
    logic [DIM*BITS-1:0] v;
    for (int i = 0; i < DIM; i++) v[i*BITS +: BITS] = lane_val(i, r);
    return {2'(r), (r == DIM-1), v};
  endfunction

  task automatic push_tile();
    for (int r = 0; r < DIM; r++) exp_q.push_back(exp_row(r));
  endtask

  // One clock: drive skewed lanes from the bench's own step count, then
  // score whatever row the DUT presents.
  task automatic tick(input logic en_v, input logic start_v);
    logic [DIM*BITS-1:0] prev;
    logic [W-1:0] e;
    int r;
    for (int i = 0; i < DIM; i++) begin
      r = tile_step - i;
      if (en_v && tile_step >= 0 && r >= 0 && r < DIM)
        cin[i*BITS +: BITS] = lane_val(i, r);
      else
        cin[i*BITS +: BITS] = 16'($urandom_range(0, 65535));
    end
    en = en_v;
    start = start_v;
    prev = cout;
    @(posedge clk); #1;
    if (en_v && tile_step >= 0) tile_step++;
    checks++;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_row got row_idx=%0d cout=%h, required no out_valid", row_idx, cout);
      end else begin
        e = exp_q.pop_front();
        if ({row_idx, done, cout} !== e) begin
          errors++;
          $display("FAIL row got idx=%0d done=%b cout=%h, required idx=%0d done=%b cout=%h",
                   row_idx, done, cout, e[W-1 -: 2], e[W-3], e[DIM*BITS-1:0]);
        end
      end
    end else if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_without_valid got done=%b, required 0", done);
    end
    if (!en_v) begin
      checks++;
      if (out_valid !== 1'b0 || cout !== prev) begin
        errors++;
        $display("FAIL stall_hold got valid=%b cout=%h, required valid=0 cout=%h", out_valid, cout, prev);
      end
    end
  endtask

  task automatic run_tile();
    tile_step = 0;
    push_tile();
    tick(1'b1, 1'b1);
    repeat (8) tick(1'b1, 1'b0);
    tile_step = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; start = 1'b1; cin = '1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cout, out_valid, busy, done, row_idx, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_state got cout=%h v=%b b=%b d=%b idx=%0d st=%0d, required all 0",
               cout, out_valid, busy, done, row_idx, dbg_state);
    end
    rst = 1'b0; en = 1'b0; start = 1'b0;
  endtask

  task automatic test_basic();
    logic exp_v, exp_b;
    mode = 0;
    tile_step = 0;
    push_tile();
    tick(1'b1, 1'b1);
    checks++;
    if (busy !== 1'b1 || dbg_state !== 2'(FILL)) begin
      errors++;
      $display("FAIL basic_start got busy=%b st=%0d, required busy=1 st=%0d", busy, dbg_state, FILL);
    end
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, 1'b0);
      exp_v = (k >= 3 && k <= 6);
      exp_b = (k <= 6);
      checks++;
      if (out_valid !== exp_v || busy !== exp_b) begin
        errors++;
        $display("FAIL basic_timing edge E%0d got valid=%b busy=%b, required valid=%b busy=%b",
                 k, out_valid, busy, exp_v, exp_b);
      end
    end
    tile_step = -1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_rows_left got %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    logic en_pat [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    mode = 0;
    tile_step = 0;
    push_tile();
    tick(1'b1, 1'b1);
    for (int k = 0; k < 12; k++) tick(en_pat[k], 1'b0);
    tile_step = -1;
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_end got rows_left=%0d busy=%b, required 0 and 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_signed();
    mode = 1;
    run_tile();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL signed_rows_left got %0d, required 0", exp_q.size());
    end
    mode = 0;
  endtask

  task automatic test_overlap();
    mode = 0;
    tile_step = 0;
    push_tile();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    repeat (6) tick(1'b1, 1'b0);
    tile_step = -1;
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overlap_end got rows_left=%0d busy=%b, required 0 and 0", exp_q.size(), busy);
    end
    run_tile();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL overlap_fresh got rows_left=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    mode = 0;
    tile_step = 0;
    push_tile();
    tick(1'b1, 1'b1);
    repeat (4) tick(1'b1, 1'b0);
    rst = 1'b1; en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({cout, out_valid, busy, done, row_idx, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_mid got cout=%h v=%b b=%b d=%b idx=%0d st=%0d, required all 0",
               cout, out_valid, busy, done, row_idx, dbg_state);
    end
    exp_q.delete();
    tile_step = -1;
    repeat (6) tick(1'b1, 1'b0);
    run_tile();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_fresh got rows_left=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_start_no_en();
    tile_step = -1;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b1);
      checks++;
      if (busy !== 1'b0 || dbg_state !== 2'(IDLE)) begin
        errors++;
        $display("FAIL start_no_en got busy=%b st=%0d, required busy=0 st=0", busy, dbg_state);
      end
    end
    repeat (5) tick(1'b1, 1'b0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_no_en_after got busy=%b, required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_signed();
    test_overlap();
    test_reset_mid();
    test_start_no_en();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
